// File: rtl/pc_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_pkg;
  localparam int PC_D      = 12;
  localparam int PC_IW     = 5;
  localparam int PC_CW     = 16;
  localparam int RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int D     = PC_D,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [D-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW:0]   cnt_q;

  assign empty = (cnt_q == '0);
  assign top   = mem[ptr_q - 1'b1];

  // Pointer wraps freely; only the occupancy count saturates at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + 1'b1;
      if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_q] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// PC register, run/halt control and retired-instruction counter.
// Define PC_RAS_EN to add the 4-entry return-address stack behind Call/Ret.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D  = PC_D,
  parameter int IW = PC_IW,
  parameter int CW = PC_CW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [D-1:0]  StartAddr,
  input  logic          Stall,
  input  logic          HaltReq,
  input  logic          Jump,
  input  logic          BranchEn,
  input  logic          Cond,
  input  logic [IW-1:0] LutIdx,
  input  logic [D-1:0]  Target,
  input  logic          Call,
  input  logic          Ret,
  output logic [IW-1:0] LutAddr,
  output logic [D-1:0]  PC,
  output logic          Running,
  output logic          Halted,
  output logic [CW-1:0] InstCnt,
  output logic          RasErr
);
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  pc_state_t     state_q, state_d;
  logic [D-1:0]  pc_q, pc_inc, pc_next;
  logic [CW-1:0] cnt_q;
  logic          running_q, halted_q;
  logic          taken;

  assign LutAddr = LutIdx;
  assign taken   = Jump | (BranchEn & Cond);
  assign pc_inc  = pc_q + 1'b1;

`ifdef PC_RAS_EN
  logic         run_go, ras_push, ras_pop, ras_empty, raserr_q;
  logic [D-1:0] ras_top;

  assign run_go   = (state_q == ST_RUN) && !Start && !Stall && !HaltReq;
  assign ras_push = run_go && !taken && Call;
  assign ras_pop  = run_go && !taken && !Call && Ret;

  pc_ras #(.D(D), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (Clk),
    .rst_n     (Reset),
    .clr       (Start),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_comb begin
    pc_next = pc_inc;
    if (taken || Call)         pc_next = Target;
    else if (Ret && !ras_empty) pc_next = ras_top;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) raserr_q <= 1'b0;
    else        raserr_q <= ras_pop && ras_empty;
  end
  assign RasErr = raserr_q;
`else
  logic unused_ret;
  assign unused_ret = Ret;

  // Without the stack a call is just a jump and a return falls through.
  always_comb begin
    pc_next = pc_inc;
    if (taken || Call) pc_next = Target;
  end
  assign RasErr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (Start)                                           state_d = ST_RUN;
    else if (state_q == ST_RUN && !Stall && HaltReq)     state_d = ST_HALT;
  end

  // Start reloads from any state; only an unstalled RUN cycle retires.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
      if (Start) begin
        pc_q  <= StartAddr;
        cnt_q <= '0;
      end else if (state_q == ST_RUN && !Stall) begin
        cnt_q <= sat_inc(cnt_q);
        if (!HaltReq) pc_q <= pc_next;
      end
    end
  end

  assign PC      = pc_q;
  assign InstCnt = cnt_q;
  assign Running = running_q;
  assign Halted  = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer, plus a CW=4 instance for saturation.
module tb_pc_sequencer;
  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, HaltReq, Jump, BranchEn, Cond, Call, Ret;
  logic [11:0] StartAddr, Target;
  logic [4:0]  LutIdx;
  logic [4:0]  LutAddr, lutaddr4;
  logic [11:0] PC, pc4;
  logic [15:0] InstCnt;
  logic [3:0]  cnt4;
  logic        Running, Halted, RasErr, running4, halted4, raserr4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .HaltReq(HaltReq), .Jump(Jump), .BranchEn(BranchEn), .Cond(Cond), .LutIdx(LutIdx),
    .Target(Target), .Call(Call), .Ret(Ret), .LutAddr(LutAddr), .PC(PC),
    .Running(Running), .Halted(Halted), .InstCnt(InstCnt), .RasErr(RasErr)
  );

  pc_sequencer #(.CW(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .HaltReq(HaltReq), .Jump(Jump), .BranchEn(BranchEn), .Cond(Cond), .LutIdx(LutIdx),
    .Target(Target), .Call(Call), .Ret(Ret), .LutAddr(lutaddr4), .PC(pc4),
    .Running(running4), .Halted(halted4), .InstCnt(cnt4), .RasErr(raserr4)
  );

  typedef struct {
    logic        start;
    logic [11:0] saddr;
    logic        stall, halt, jump, br, cond;
    logic [4:0]  idx;
    logic [11:0] tgt;
    logic        call, ret;
    logic [11:0] epc;
    logic [15:0] ecnt;
    logic        erun, ehalt, eerr;
  } vec_t;

  function automatic vec_t ex(input logic [11:0] pc, input logic [15:0] cnt,
                              input logic run, input logic hlt);
    vec_t v;
    v.start = 0; v.saddr = '0; v.stall = 0; v.halt = 0; v.jump = 0; v.br = 0;
    v.cond = 0; v.idx = '0; v.tgt = '0; v.call = 0; v.ret = 0;
    v.epc = pc; v.ecnt = cnt; v.erun = run; v.ehalt = hlt; v.eerr = 0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    Start = v.start; StartAddr = v.saddr; Stall = v.stall; HaltReq = v.halt;
    Jump = v.jump; BranchEn = v.br; Cond = v.cond; LutIdx = v.idx; Target = v.tgt;
    Call = v.call; Ret = v.ret;
  endtask

  // Called on a falling edge: drive, check LutAddr, clock once, check state.
  task automatic apply(input vec_t v, input string nm);
    drive(v);
    #1 chk({nm, ".lutaddr"}, 32'(LutAddr), 32'(v.idx));
    @(posedge Clk);
    #1;
    chk({nm, ".pc"}, 32'(PC), 32'(v.epc));
    chk({nm, ".cnt"}, 32'(InstCnt), 32'(v.ecnt));
    chk({nm, ".running"}, 32'(Running), 32'(v.erun));
    chk({nm, ".halted"}, 32'(Halted), 32'(v.ehalt));
    chk({nm, ".raserr"}, 32'(RasErr), 32'(v.eerr));
    @(negedge Clk);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [11:0] ret_exp [5];

    v = ex(12'h000, 0, 0, 0); v.jump = 1; v.tgt = 12'h055; tbl.push_back(v);
    v = ex(12'h000, 0, 1, 0); v.start = 1; tbl.push_back(v);
    for (int i = 1; i <= 5; i++) tbl.push_back(ex(12'(i), 16'(i), 1, 0));
    v = ex(12'hFFE, 0, 1, 0); v.start = 1; v.saddr = 12'hFFE; tbl.push_back(v);
    tbl.push_back(ex(12'hFFF, 1, 1, 0));
    tbl.push_back(ex(12'h000, 2, 1, 0));
    tbl.push_back(ex(12'h001, 3, 1, 0));
    v = ex(12'h028, 4, 1, 0); v.br = 1; v.cond = 1; v.idx = 1; v.tgt = 12'd40; tbl.push_back(v);
    v = ex(12'h029, 5, 1, 0); v.br = 1; v.cond = 0; v.idx = 2; v.tgt = 12'd99; tbl.push_back(v);
    v = ex(12'h0C3, 6, 1, 0); v.jump = 1; v.br = 1; v.idx = 3; v.tgt = 12'h0C3; tbl.push_back(v);
    v = ex(12'h0C3, 6, 1, 0); v.jump = 1; v.stall = 1; v.tgt = 12'h300; tbl.push_back(v);
    tbl.push_back(ex(12'h0C4, 7, 1, 0));
    v = ex(12'h0C4, 8, 0, 1); v.halt = 1; v.jump = 1; v.tgt = 12'h200; tbl.push_back(v);
    v = ex(12'h0C4, 8, 0, 1); v.jump = 1; v.call = 1; v.idx = 31; v.tgt = 12'h123; tbl.push_back(v);

    Reset = 1'b0;
    drive(ex(0, 0, 0, 0));
    @(negedge Clk);
    #1;
    chk("reset.pc", 32'(PC), 0);
    chk("reset.cnt", 32'(InstCnt), 0);
    chk("reset.running", 32'(Running), 0);
    chk("reset.halted", 32'(Halted), 0);
    chk("reset.raserr", 32'(RasErr), 0);
    @(negedge Clk);
    Reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    for (int i = 0; i < 10; i++) apply(ex(12'h0C4, 8, 0, 1), "halt_hold");
    v = ex(12'h000, 0, 1, 0); v.start = 1; apply(v, "restart");

    // Asynchronous reset mid-run at PC=0x025.
    v = ex(12'h020, 0, 1, 0); v.start = 1; v.saddr = 12'h020; apply(v, "start20");
    for (int i = 1; i <= 5; i++) apply(ex(12'h020 + 12'(i), 16'(i), 1, 0), "run20");
    #2 Reset = 1'b0;
    #1;
    chk("areset.pc", 32'(PC), 0);
    chk("areset.cnt", 32'(InstCnt), 0);
    chk("areset.running", 32'(Running), 0);
    @(negedge Clk);
    chk("areset_hold.pc", 32'(PC), 0);
    Reset = 1'b1;

    // Call then Ret; Call+Ret together.
    v = ex(12'h010, 0, 1, 0); v.start = 1; v.saddr = 12'h010; apply(v, "cr.start");
    v = ex(12'h0B8, 1, 1, 0); v.call = 1; v.tgt = 12'h0B8; apply(v, "cr.call");
`ifdef PC_RAS_EN
    v = ex(12'h011, 2, 1, 0); v.ret = 1; apply(v, "cr.ret");
`else
    v = ex(12'h0B9, 2, 1, 0); v.ret = 1; apply(v, "cr.ret");
`endif
    v = ex(12'h0A0, 3, 1, 0); v.call = 1; v.ret = 1; v.tgt = 12'h0A0; apply(v, "cr.both");

    // Five nested calls then five returns; the fifth push overwrites 0x101.
    v = ex(12'h100, 0, 1, 0); v.start = 1; v.saddr = 12'h100; apply(v, "nest.start");
    for (int i = 1; i <= 5; i++) begin
      v = ex(12'(i + 1) << 8, 16'(i), 1, 0); v.call = 1; v.tgt = 12'(i + 1) << 8;
      apply(v, "nest.call");
    end
`ifdef PC_RAS_EN
    ret_exp = '{12'h501, 12'h401, 12'h301, 12'h201, 12'h202};
`else
    ret_exp = '{12'h601, 12'h602, 12'h603, 12'h604, 12'h605};
`endif
    for (int i = 0; i < 5; i++) begin
      v = ex(ret_exp[i], 16'(6 + i), 1, 0); v.ret = 1;
`ifdef PC_RAS_EN
      v.eerr = (i == 4);
`endif
      apply(v, "nest.ret");
    end
    apply(ex(ret_exp[4] + 12'h001, 11, 1, 0), "nest.after");

    // Start clears the stack.
    v = ex(12'h700, 0, 1, 0); v.start = 1; v.saddr = 12'h700; apply(v, "clr.start");
    v = ex(12'h710, 1, 1, 0); v.call = 1; v.tgt = 12'h710; apply(v, "clr.call");
    v = ex(12'h720, 0, 1, 0); v.start = 1; v.saddr = 12'h720; apply(v, "clr.restart");
    v = ex(12'h721, 1, 1, 0); v.ret = 1;
`ifdef PC_RAS_EN
    v.eerr = 1;
`endif
    apply(v, "clr.ret");

    // Counter saturation on the CW=4 instance.
    v = ex(12'h000, 0, 1, 0); v.start = 1; apply(v, "sat.start");
    for (int i = 1; i <= 20; i++) begin
      apply(ex(12'(i), 16'(i), 1, 0), "sat.run");
      chk("sat.cnt4", 32'(cnt4), (i > 15) ? 32'hF : 32'(i));
    end
    chk("sat.pc4", 32'(pc4), 32'h014);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer for the 12-bit instruction space.
- Owns the PC register and run/halt control.
- Issues the 5-bit jump-table index to the combinational jump-target LUT and consumes the returned absolute target.
- Sits between the decoder (branch/halt requests) and instruction ROM (PC output); tracks retired-instruction count for program benchmarking.

Parameters:
- D, 12, PC / target width.
- IW, 5, jump-table index width.
- CW, 16, retired-instruction counter width.

Ports:
- Clk  input  1  clock; all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  launch/relaunch a program; single-cycle pulse.
- StartAddr  input  D  PC loaded on Start.
- Stall  input  1  hold PC this cycle.
- HaltReq  input  1  decoder saw halt/done instruction.
- Jump  input  1  unconditional jump this cycle.
- BranchEn  input  1  conditional-branch instruction this cycle.
- Cond  input  1  ALU flag for BranchEn.
- LutIdx  input  IW  jump-table index from instruction field.
- Target  input  D  absolute target returned by LUT (combinational from LutAddr).
- Call  input  1  call request (see Optional Feature).
- Ret  input  1  return request (see Optional Feature).
- LutAddr  output  IW  index to LUT; combinational pass-through of LutIdx.
- PC  output  D  current fetch address.
- Running  output  1  high in RUN.
- Halted  output  1  high in HALT.
- InstCnt  output  CW  retired instructions since last Start.
- RasErr  output  1  one-cycle pulse on return-stack underflow.

Behaviour:
- Reset (async, Reset=0): state IDLE, PC=0, InstCnt=0, Running=0, Halted=0, RasErr=0, return stack emptied. Reset mid-program aborts immediately; no partial update survives.
- States: IDLE, RUN, HALT. Encoding is an enum in the package.
- IDLE: PC held. Start -> RUN with PC=StartAddr, InstCnt=0. All other inputs ignored.
- RUN priority per cycle, highest first:
  1. Start: restart as from IDLE.
  2. Stall: PC, InstCnt hold; branch/halt/call/ret inputs ignored.
  3. HaltReq: -> HALT; PC holds; InstCnt+1.
  4. Taken branch (Jump | (BranchEn & Cond)): PC<=Target.
  5. Call/Ret: per Optional Feature.
  6. Otherwise: PC<=PC+1.
- Steps 4-6 each increment InstCnt.
- BranchEn with Cond=0 is PC+1.
- Jump and BranchEn together: the jump is taken.
- HALT: PC, InstCnt frozen; Halted=1. Start -> RUN (restart). No other exit.
- Arithmetic: PC+1 is modulo 2^D (0xFFF -> 0x000, no flag). InstCnt saturates at all-ones.
- Latency: one cycle; requests sampled at edge N give new PC after edge N. LutAddr=LutIdx combinationally, so Target is valid in the same cycle.
- Running/Halted are registered decodes of state; never both high.

Optional Feature:
- Macro PC_RAS_EN.
- Defined: 4-entry return-address stack.
  - Call (RUN, not stalled, no taken branch): push PC+1, PC<=Target.
  - Ret: pop into PC.
  - Push when full overwrites the oldest entry (circular, depth stays 4).
  - Ret when empty: PC<=PC+1, RasErr pulses 1 cycle.
  - Call and Ret together: Call wins.
  - Stack cleared on reset and on Start.
- Undefined: Call behaves as Jump, Ret as no-op (PC+1), RasErr tied 0; ports remain for a stable interface.

Decomposition:
- Shared package pc_pkg: state enum (IDLE/RUN/HALT), D/IW/CW defaults, RAS depth constant (4).
- One sub-module: pc_ras (stack storage, pointer, count, push/pop/overflow logic), instantiated only under PC_RAS_EN.

Test Plan:
- Reset low mid-RUN at PC=0x025 -> PC=0, IDLE, InstCnt=0 immediately, without waiting for a clock edge.
- Start with StartAddr=0x000, 5 free cycles -> PC=5, InstCnt=5. Start with StartAddr=0xFFE, 3 cycles -> PC=0x001, wrapping through 0x000.
- BranchEn=1, Cond=1, LutIdx=1, Target=40 -> LutAddr=1, next PC=40. Same with Cond=0 -> PC+1.
- Jump=1 with Stall=1 -> PC and InstCnt unchanged. HaltReq at PC=0x0C4 -> Halted=1, PC stays 0x0C4 for 10 cycles. Start with StartAddr=0 -> Running=1, PC=0.
- PC_RAS_EN defined:
  - Call at PC=0x010 with Target=0x0B8, then Ret -> PC 0x0B8, then 0x011.
  - 5 nested calls, 5 returns -> last return underflows: RasErr=1 one cycle, PC+1.
- InstCnt forced near max (CW=4 build): 20 free cycles -> InstCnt holds at 0xF.
